perip_riego_sched: RTL

- Memory-mapped irrigation sequencer on the SoC peripheral bus, at chip-select slot 0x00440000 (cs_chip4).
- Replaces CPU bit-banging of the ESP32 handshake and the valve line with a hardware cycle: request the ESP, wait for ready with a timeout, open the valve for a programmed time, then hold off.
- Repeats the cycle automatically when enabled.
- The CPU configures it and polls status through the same d_in/addr/rd/wr/d_out bus as the other peripherals.

---
 rtl/riego_pkg.sv | 43 ++++
 rtl/riego_tick_gen.sv | 37 +++
 rtl/perip_riego_sched.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/riego_pkg.sv
// Shared encodings for the irrigation sequencer: FSM states, register offsets,
// CTRL/STATUS bit positions and the STATUS word packer.
package riego_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RDY = 2'd1,
        IRRIGATE = 2'd2,
        HOLDOFF  = 2'd3
    } state_t;

    localparam logic [2:0] REG_CTRL      = 3'd0;
    localparam logic [2:0] REG_VALVE_T   = 3'd1;
    localparam logic [2:0] REG_HOLD_T    = 3'd2;
    localparam logic [2:0] REG_TIMEOUT_T = 3'd3;
    localparam logic [2:0] REG_STATUS    = 3'd4;
    localparam logic [2:0] REG_CYCLES    = 3'd5;
    localparam logic [2:0] REG_DBG_TCNT  = 3'd6;
    localparam logic [2:0] REG_DBG_PRESC = 3'd7;

    localparam int unsigned CTRL_START     = 0;
    localparam int unsigned CTRL_AUTO      = 1;
    localparam int unsigned CTRL_ABORT     = 2;
    localparam int unsigned CTRL_CLR_FLAGS = 3;

    localparam int unsigned ST_BUSY  = 2;
    localparam int unsigned ST_DONE  = 3;
    localparam int unsigned ST_TOERR = 4;
    localparam int unsigned ST_RDY   = 5;

    function automatic logic [31:0] status_word(input state_t s, input logic done,
                                                input logic toerr, input logic rdy);
        logic [31:0] w;
        w           = '0;
        w[1:0]      = s;
        w[ST_BUSY]  = (s != IDLE);
        w[ST_DONE]  = done;
        w[ST_TOERR] = toerr;
        w[ST_RDY]   = rdy;
        return w;
    endfunction

endpackage

// File: rtl/riego_tick_gen.sv
// Timing-tick prescaler: counts 0..TICK_DIV-1 and pulses tick at the wrap.
// restart zeroes the count so the next tick lands exactly TICK_DIV clks later.
module riego_tick_gen #(
    parameter int unsigned TICK_DIV = 25000,
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          restart,
    output logic          tick
`ifdef RIEGO_SCHED_DBG_EN
    ,
    output logic [PW-1:0] count
`endif
);

    logic [PW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == PW'(TICK_DIV - 1));
    assign tick = wrap;

`ifdef RIEGO_SCHED_DBG_EN
    assign count = cnt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/perip_riego_sched.sv
// Memory-mapped irrigation sequencer: ESP32 handshake, timed valve pulse, hold-off.
// Optional RIEGO_SCHED_DBG_EN exposes tick counter / prescaler at offsets 6 and 7.
module perip_riego_sched #(
    parameter int unsigned TICK_DIV = 25000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] d_in,
    input  logic        cs,
    input  logic [31:0] addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out,
    input  logic        ready_from_esp,
    output logic        enable_esp,
    output logic        led_valvula,
    output logic        irq
);
    import riego_pkg::*;

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] valve_t, hold_t, tmo_t, cycles, tcnt;
    logic [CNT_W-1:0] tcnt_inc, tcnt_view, valve_eff, hold_eff, tmo_eff;
    logic             auto_en, auto_eff, done, toerr, done_nxt, toerr_nxt;
    logic             rdy_meta, rdy_sync;
    logic             wr_en, rd_en, start, abort, clr;
    logic             set_done, set_toerr, inc_cycles;
    logic             tick, restart;
    logic [2:0]       sel;
    logic [31:0]      rdata;
    logic             unused_bits;

    assign wr_en = cs & wr;
    assign rd_en = cs & rd;
    assign sel   = addr[4:2];
    assign unused_bits = &{1'b0, addr[31:5], addr[1:0], d_in};

    assign start = wr_en && (sel == REG_CTRL) && d_in[CTRL_START];
    assign abort = wr_en && (sel == REG_CTRL) && d_in[CTRL_ABORT];
    assign clr   = wr_en && (sel == REG_CTRL) && d_in[CTRL_CLR_FLAGS];

    // Config written this clk is compared immediately, not one clk later.
    assign valve_eff = (wr_en && sel == REG_VALVE_T)   ? d_in[CNT_W-1:0] : valve_t;
    assign hold_eff  = (wr_en && sel == REG_HOLD_T)    ? d_in[CNT_W-1:0] : hold_t;
    assign tmo_eff   = (wr_en && sel == REG_TIMEOUT_T) ? d_in[CNT_W-1:0] : tmo_t;
    assign auto_eff  = (wr_en && sel == REG_CTRL)      ? d_in[CTRL_AUTO] : auto_en;

    assign restart = (state_nxt != state);

`ifdef RIEGO_SCHED_DBG_EN
    logic [PW-1:0] presc_cnt;

    riego_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick),
        .count   (presc_cnt)
    );
`else
    riego_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );
`endif

    always_comb begin
        tcnt_inc   = (tcnt == '1) ? tcnt : tcnt + 1'b1;
        // Compare against the value the counter takes this edge so an exit
        // coincides with the tick that completes the interval.
        tcnt_view  = tick ? tcnt_inc : tcnt;
        state_nxt  = state;
        set_done   = 1'b0;
        set_toerr  = 1'b0;
        inc_cycles = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state_nxt = WAIT_RDY;
                end
                WAIT_RDY: begin
                    if (rdy_sync) begin
                        state_nxt = IRRIGATE;
                    end else if (tmo_eff != '0 && tcnt_view >= tmo_eff) begin
                        state_nxt = IDLE;
                        set_toerr = 1'b1;
                    end
                end
                IRRIGATE: begin
                    if (tcnt_view >= valve_eff) state_nxt = HOLDOFF;
                end
                HOLDOFF: begin
                    if (tcnt_view >= hold_eff) begin
                        set_done   = 1'b1;
                        inc_cycles = 1'b1;
                        state_nxt  = auto_eff ? WAIT_RDY : IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        done_nxt  = set_done  | (done  & ~clr);
        toerr_nxt = set_toerr | (toerr & ~clr);
    end

    always_comb begin
        rdata = '0;
        case (sel)
            REG_CTRL:      rdata[CTRL_AUTO] = auto_en;
            REG_VALVE_T:   rdata = 32'(valve_t);
            REG_HOLD_T:    rdata = 32'(hold_t);
            REG_TIMEOUT_T: rdata = 32'(tmo_t);
            REG_STATUS:    rdata = status_word(state, done, toerr, rdy_sync);
            REG_CYCLES:    rdata = 32'(cycles);
`ifdef RIEGO_SCHED_DBG_EN
            REG_DBG_TCNT:  rdata = 32'(tcnt);
            REG_DBG_PRESC: rdata = 32'(presc_cnt);
`endif
            default:       rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            enable_esp  <= 1'b0;
            led_valvula <= 1'b0;
            irq         <= 1'b0;
            tcnt        <= '0;
            valve_t     <= '0;
            hold_t      <= '0;
            tmo_t       <= '0;
            cycles      <= '0;
            auto_en     <= 1'b0;
            done        <= 1'b0;
            toerr       <= 1'b0;
            d_out       <= '0;
            rdy_meta    <= 1'b0;
            rdy_sync    <= 1'b0;
        end else begin
            state       <= state_nxt;
            enable_esp  <= (state_nxt == WAIT_RDY);
            // A zero valve time passes through IRRIGATE without opening the valve.
            led_valvula <= (state_nxt == IRRIGATE) && (valve_eff != '0);
            irq         <= done_nxt | toerr_nxt;
            done        <= done_nxt;
            toerr       <= toerr_nxt;
            rdy_meta    <= ready_from_esp;
            rdy_sync    <= rdy_meta;

            if (restart) begin
                tcnt <= '0;
            end else if (tick) begin
                tcnt <= tcnt_inc;
            end

            if (inc_cycles) cycles <= cycles + 1'b1;

            if (wr_en) begin
                case (sel)
                    REG_CTRL:      auto_en <= d_in[CTRL_AUTO];
                    REG_VALVE_T:   valve_t <= d_in[CNT_W-1:0];
                    REG_HOLD_T:    hold_t  <= d_in[CNT_W-1:0];
                    REG_TIMEOUT_T: tmo_t   <= d_in[CNT_W-1:0];
                    default: ;
                endcase
            end

            if (rd_en) d_out <= rdata;
        end
    end

endmodule
